usb_gpx_conditioner: RTL and testbench

USB_GPX_CONDITIONER -- requirements
Module: usb_gpx_conditioner

---
 rtl/usb_gpx_conditioner.sv | 168 ++++++++++++++++
 tb/tb_usb_gpx_conditioner.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_gpx_conditioner.sv
// usb_gpx_conditioner
// Conditions the GPX pin of the MAX3421E USB controller for a Nios II system.
// The raw pin is synchronized and then debounced. The accepted level drives the
// downstream GPX PIO. Accepted edges are latched as interrupt sources, and an
// Avalon-MM slave exposes the level, the edge latches, the mask and a count of
// rising edges.
//
// Register map (word addresses)
//   0  R   {30'b0, sync2, gpx_out}          write ignored
//   1  RW  {30'b0, edge_cap}                write-1-to-clear
//   2  RW  {30'b0, irq_mask}                loads from writedata[1:0]
//   3  RW  zero-extended rise_cnt           any write clears the counter

module usb_gpx_conditioner #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpx_pin,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        gpx_out,
  output logic        irq
);

  // The stability counter reaches this value on the last differing sample
  // before a new level is accepted.
  localparam logic [7:0] FILTER_LAST = 8'(FILTER_CYCLES - 1);

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  logic             sync1;
  logic             sync2;
  logic [7:0]       stab_cnt;
  logic             gpx_prev;
  logic [1:0]       edge_cap;
  logic [1:0]       irq_mask;
  logic [CNT_W-1:0] rise_cnt;

  logic             rise_evt;
  logic             fall_evt;
  logic             wr_edge;
  logic             wr_mask;
  logic             wr_count;
  logic [31:0]      read_mux;
  logic             unused_writedata;

  // Only writedata[1:0] carries meaning. The upper bits are folded here so
  // that they are visibly consumed.
  assign unused_writedata = ^writedata[31:2];

  // Decode the register writes once so that the register blocks stay simple.
  assign wr_edge  = write && (address == ADDR_EDGE);
  assign wr_mask  = write && (address == ADDR_MASK);
  assign wr_count = write && (address == ADDR_COUNT);

  // An edge of the filtered level is seen one cycle after gpx_out changes.
  // gpx_prev is reset together with gpx_out, so reset deassertion alone can
  // never produce an edge.
  assign rise_evt = gpx_out && !gpx_prev;
  assign fall_evt = !gpx_out && gpx_prev;

  // The interrupt line is built only from registered state, so it cannot glitch
  // on bus activity.
  assign irq = |(edge_cap & irq_mask);

  // Two-flop synchronizer: the asynchronous pin is used only after sync2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= gpx_pin;
      sync2 <= sync1;
    end
  end

  // Debounce filter. The counter measures how long sync2 has disagreed with
  // the accepted level. The level flips on the FILTER_CYCLES-th consecutive
  // disagreement. Any single agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpx_out  <= 1'b0;
      stab_cnt <= 8'd0;
    end else if (sync2 != gpx_out) begin
      if (stab_cnt == FILTER_LAST) begin
        gpx_out  <= ~gpx_out;
        stab_cnt <= 8'd0;
      end else begin
        stab_cnt <= stab_cnt + 8'd1;
      end
    end else begin
      stab_cnt <= 8'd0;
    end
  end

  // Remember the previous filtered level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpx_prev <= 1'b0;
    end else begin
      gpx_prev <= gpx_out;
    end
  end

  // Edge latches. Software clears a bit by writing 1 to it. A new edge arriving
  // in the same cycle wins, so an edge is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= 2'b00;
    end else begin
      edge_cap <= (wr_edge ? (edge_cap & ~writedata[1:0]) : edge_cap)
                  | {fall_evt, rise_evt};
    end
  end

  // Interrupt mask, loaded directly by software.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= 2'b00;
    end else if (wr_mask) begin
      irq_mask <= writedata[1:0];
    end
  end

  // Rising-edge counter. It wraps naturally at 2^CNT_W. If a clear and a
  // rising edge happen together, the counter restarts with that edge counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_cnt <= '0;
    end else if (wr_count) begin
      rise_cnt <= rise_evt ? CNT_W'(1) : '0;
    end else if (rise_evt) begin
      rise_cnt <= rise_cnt + CNT_W'(1);
    end
  end

  // Read multiplexer. It selects from the current registered values, so a
  // same-cycle write is not visible to the read.
  always_comb begin
    read_mux = 32'd0;
    case (address)
      ADDR_LEVEL: read_mux = {30'd0, sync2, gpx_out};
      ADDR_EDGE:  read_mux = {30'd0, edge_cap};
      ADDR_MASK:  read_mux = {30'd0, irq_mask};
      ADDR_COUNT: read_mux = 32'(rise_cnt);
      default:    read_mux = 32'd0;
    endcase
  end

  // Registered read data with a latency of one cycle. The value holds between
  // reads, and reads change no other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (read) begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// tb_usb_gpx_conditioner
// Self-checking bench for usb_gpx_conditioner. The main instance uses the
// default parameters. A second instance with FILTER_CYCLES=1 and CNT_W=3
// shares all inputs and covers the shortest filter and counter wrap.
// A behavioural model tracks the main instance. Its filter rule is "flip when
// the last F synchronized samples all disagree with the level".

module tb_usb_gpx_conditioner;

  localparam int F = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        gpx_pin = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        gpx_out;
  logic        irq;
  logic [31:0] s_readdata;
  logic        s_gpx_out;
  logic        s_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_gpx_conditioner #(.FILTER_CYCLES(F), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .gpx_pin(gpx_pin), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .gpx_out(gpx_out), .irq(irq)
  );

  usb_gpx_conditioner #(.FILTER_CYCLES(1), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .gpx_pin(gpx_pin), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(s_readdata), .gpx_out(s_gpx_out), .irq(s_irq)
  );

  // Reference model state
  logic [1:0]  m_samp;
  logic [F-1:0] m_win;
  logic        m_out, m_prev;
  logic [1:0]  m_cap, m_mask;
  logic [15:0] m_cnt;
  logic [31:0] m_rd;
  logic        m_irq;

  assign m_irq = |(m_cap & m_mask);

  // Behavioural model. It steps once per clock, and the asynchronous reset
  // clears everything.
  always @(posedge clk or posedge reset) begin : model
    logic s2, rise, fall, nxt;
    logic [1:0] cap;
    if (reset) begin
      m_samp = 2'b00; m_win = '0; m_out = 1'b0; m_prev = 1'b0;
      m_cap = 2'b00; m_mask = 2'b00; m_cnt = 16'd0; m_rd = 32'd0;
    end else begin
      s2   = m_samp[1];
      rise = m_out && !m_prev;
      fall = !m_out && m_prev;
      if (read) begin
        case (address)
          2'd0: m_rd = {30'd0, s2, m_out};
          2'd1: m_rd = {30'd0, m_cap};
          2'd2: m_rd = {30'd0, m_mask};
          default: m_rd = {16'd0, m_cnt};
        endcase
      end
      m_win = {m_win[F-2:0], s2};
      nxt = (m_win == {F{~m_out}}) ? ~m_out : m_out;
      cap = m_cap;
      if (write && address == 2'd1) cap = cap & ~writedata[1:0];
      m_cap = cap | {fall, rise};
      if (write && address == 2'd2) m_mask = writedata[1:0];
      if (write && address == 2'd3) m_cnt = rise ? 16'd1 : 16'd0;
      else if (rise) m_cnt = m_cnt + 16'd1;
      m_prev = m_out;
      m_out  = nxt;
      m_samp = {m_samp[0], gpx_pin};
    end
  end

  // Bus and stimulus helpers
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; gpx_pin = 1'b0; read = 1'b0; write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] sd);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata; sd = s_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    @(negedge clk); gpx_pin = 1'b1;
    repeat (hi) @(negedge clk);
    gpx_pin = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d, sd;
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, d, sd);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (readdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_readdata: got %h expected 0", readdata); end
    checks++; if (gpx_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_gpx_out: got %b expected 0", gpx_out); end
    checks++; if (irq !== 1'b0 || s_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b/%b expected 0", irq, s_irq); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(2'd2, d, sd);
    checks++; if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_irq_mask: got %h expected 0", d); end
  endtask

  task automatic test_latency();
    logic [31:0] d, sd;
    logic exp;
    do_reset();
    @(negedge clk); gpx_pin = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      exp = (e >= 6);
      checks++; if (gpx_out !== exp) begin errors++; $display("[TB] FAIL latency_gpx_out edge %0d: got %b expected %b", e, gpx_out, exp); end
      exp = (e >= 3);
      checks++; if (s_gpx_out !== exp) begin errors++; $display("[TB] FAIL latency_small_gpx_out edge %0d: got %b expected %b", e, s_gpx_out, exp); end
    end
    bus_read(2'd1, d, sd);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL latency_edge_cap: got %h expected 1", d); end
    bus_read(2'd3, d, sd);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL latency_rise_cnt: got %h expected 1", d); end
    bus_read(2'd0, d, sd);
    checks++; if (d !== 32'h3) begin errors++; $display("[TB] FAIL latency_level: got %h expected 3", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, sd;
    logic seen;
    do_reset();
    seen = 1'b0;
    @(negedge clk); gpx_pin = 1'b1;
    repeat (3) @(negedge clk);
    gpx_pin = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (gpx_out !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("[TB] FAIL glitch_gpx_out: got a change expected none"); end
    bus_read(2'd1, d, sd);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_edge_cap: got %h expected 0", d); end
    bus_read(2'd3, d, sd);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_rise_cnt: got %h expected 0", d); end
    pulse(4, 12);
    bus_read(2'd3, d, sd);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL min_pulse_rise_cnt: got %h expected 1", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d, sd;
    do_reset();
    bus_write(2'd2, 32'h1);
    @(negedge clk); gpx_pin = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_on_rise: got %b expected 1", irq); end
    bus_write(2'd1, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_w1c: got %b expected 0", irq); end
    gpx_pin = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(2'd1, d, sd);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL irq_fall_edge_cap: got %h expected 2", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_masked_fall: got %b expected 0", irq); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d, sd;
    do_reset();
    bus_write(2'd2, 32'h1);
    @(negedge clk); gpx_pin = 1'b1;
    repeat (6) @(negedge clk);
    address = 2'd1; writedata = 32'h1; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL w1c_collision_irq: got %b expected 1", irq); end
    bus_read(2'd1, d, sd);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL w1c_collision_edge_cap: got %h expected 1", d); end
  endtask

  task automatic test_cnt_clear_collision();
    logic [31:0] d, sd;
    do_reset();
    repeat (3) pulse(10, 10);
    bus_read(2'd3, d, sd);
    checks++; if (d !== 32'h3) begin errors++; $display("[TB] FAIL cnt_three_pulses: got %h expected 3", d); end
    @(negedge clk); gpx_pin = 1'b1;
    repeat (6) @(negedge clk);
    address = 2'd3; writedata = 32'h0; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    bus_read(2'd3, d, sd);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL cnt_clear_collision: got %h expected 1", d); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d, sd);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL cnt_plain_clear: got %h expected 0", d); end
  endtask

  task automatic test_read_write_same();
    logic [31:0] d, sd;
    do_reset();
    bus_write(2'd2, 32'h2);
    @(negedge clk);
    address = 2'd2; read = 1'b1; write = 1'b1; writedata = 32'h1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    checks++; if (readdata !== 32'h2) begin errors++; $display("[TB] FAIL rw_same_old_value: got %h expected 2", readdata); end
    repeat (3) @(negedge clk);
    checks++; if (readdata !== 32'h2) begin errors++; $display("[TB] FAIL readdata_hold: got %h expected 2", readdata); end
    bus_read(2'd2, d, sd);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL rw_same_new_value: got %h expected 1", d); end
  endtask

  task automatic test_reset_midfilter();
    logic [31:0] d, sd;
    logic exp;
    do_reset();
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, d, sd);
    @(negedge clk); gpx_pin = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (gpx_out !== 1'b0 || irq !== 1'b0 || readdata !== 32'd0) begin
      errors++; $display("[TB] FAIL midfilter_reset_outputs: got %b %b %h expected 0 0 0", gpx_out, irq, readdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      exp = (e >= 6);
      checks++; if (gpx_out !== exp) begin errors++; $display("[TB] FAIL midfilter_gpx_out edge %0d: got %b expected %b", e, gpx_out, exp); end
    end
    repeat (2) @(negedge clk);
    bus_read(2'd3, d, sd);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL midfilter_rise_cnt: got %h expected 1", d); end
    bus_read(2'd0, d, sd);
    checks++; if (d !== 32'h3) begin errors++; $display("[TB] FAIL midfilter_level: got %h expected 3", d); end
    gpx_pin = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] d, sd;
    do_reset();
    repeat (7) pulse(10, 10);
    bus_read(2'd3, d, sd);
    checks++; if (sd !== 32'h7 || d !== 32'h7) begin errors++; $display("[TB] FAIL wrap_at_max: got %h/%h expected 7/7", sd, d); end
    pulse(10, 10);
    bus_read(2'd3, d, sd);
    checks++; if (sd !== 32'h0) begin errors++; $display("[TB] FAIL wrap_to_zero: got %h expected 0", sd); end
    checks++; if (d !== 32'h8) begin errors++; $display("[TB] FAIL wrap_wide_count: got %h expected 8", d); end
    pulse(10, 10);
    bus_read(2'd3, d, sd);
    checks++; if (sd !== 32'h1) begin errors++; $display("[TB] FAIL wrap_after_zero: got %h expected 1", sd); end
  endtask

  task automatic test_random();
    int hold, op;
    do_reset();
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checks++; if (gpx_out !== m_out) begin errors++; $display("[TB] FAIL rand_gpx_out cycle %0d: got %b expected %b", cyc, gpx_out, m_out); end
      checks++; if (irq !== m_irq) begin errors++; $display("[TB] FAIL rand_irq cycle %0d: got %b expected %b", cyc, irq, m_irq); end
      checks++; if (readdata !== m_rd) begin errors++; $display("[TB] FAIL rand_readdata cycle %0d: got %h expected %h", cyc, readdata, m_rd); end
      if (hold == 0) begin
        gpx_pin = ~gpx_pin;
        hold = $urandom_range(1, 8);
      end
      hold--;
      read = 1'b0; write = 1'b0;
      op = $urandom_range(0, 11);
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      if (op <= 3) read = 1'b1;
      else if (op <= 6) begin
        write = 1'b1;
        read = 1'($urandom_range(0, 1));
        if (address == 2'd3 && $urandom_range(0, 3) != 0) write = 1'b0;
      end
    end
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    $display("[TB] starting");
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_w1c_collision();
    test_cnt_clear_collision();
    test_read_write_same();
    test_reset_midfilter();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
